// File: rtl/wb_sram_arb_pkg.sv
// Shared definitions for the two-master Wishbone SRAM arbiter:
// FSM state encoding and default parameter values.
package wb_sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        QUIET = 2'd2
    } arb_state_t;

    localparam int ARB_AW        = 17;
    localparam int ARB_TMO_CYC   = 48;
    localparam int ARB_QUIET_CYC = 32;

endpackage

// File: rtl/wb_sram_arb_rr.sv
// Two-way round-robin picker. A lone requester wins outright; when both
// request, the master that was not served last wins. Pure combinational.
module wb_sram_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    // grant = 1 selects m1; m1 wins when alone, or in a tie when m0 was served last
    always_comb begin
        grant = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/wb_sram_arb.sv
// Two-master Wishbone arbiter in front of the byte-serial SRAM slave.
// m0 = instruction fetch, m1 = data/DMA. The grant is held until the slave
// acks; an owner that drops cyc mid-cycle still waits for the ack, which is
// swallowed. Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_sram_arb
    import wb_sram_arb_pkg::*;
#(
    parameter int AW        = ARB_AW,
    parameter int TMO_CYC   = ARB_TMO_CYC,
    parameter int QUIET_CYC = ARB_QUIET_CYC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i
);

    if (TMO_CYC < 2 || QUIET_CYC < 1 || AW < 1) begin : g_bad_cfg
        $error("wb_sram_arb: need AW >= 1, TMO_CYC >= 2, QUIET_CYC >= 1");
    end

    arb_state_t state_q, state_nx;
    logic       owner_q, owner_nx;
    logic       last_q, last_nx;
    logic       cyc_q, cyc_nx;
    logic       abort_q, abort_nx;
    logic [1:0] req;
    logic       pick;
    logic       owner_cyc;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(((TMO_CYC > QUIET_CYC) ? TMO_CYC : QUIET_CYC) + 1);
    logic [CNT_W-1:0] cnt_q, cnt_nx;
`endif

    assign req      = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign s_cyc_o  = cyc_q;
    assign s_stb_o  = cyc_q;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    wb_sram_arb_rr u_rr (
        .req   (req),
        .last  (last_q),
        .grant (pick)
    );

    // Route the registered owner's request onto the slave port
    always_comb begin
        if (owner_q) begin
            s_adr_o   = m1_adr_i;
            s_dat_o   = m1_dat_i;
            s_sel_o   = m1_sel_i;
            s_we_o    = m1_we_i;
            owner_cyc = m1_cyc_i;
        end else begin
            s_adr_o   = m0_adr_i;
            s_dat_o   = m0_dat_i;
            s_sel_o   = m0_sel_i;
            s_we_o    = m0_we_i;
            owner_cyc = m0_cyc_i;
        end
    end

    // Arbiter state, ownership and slave strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cyc_q   <= 1'b0;
            abort_q <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_nx;
            owner_q <= owner_nx;
            last_q  <= last_nx;
            cyc_q   <= cyc_nx;
            abort_q <= abort_nx;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_nx;
`endif
        end
    end

    // Next-state logic plus combinational ack/err steering to the owner
    always_comb begin
        state_nx = state_q;
        owner_nx = owner_q;
        last_nx  = last_q;
        cyc_nx   = cyc_q;
        abort_nx = abort_q;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_nx   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_nx = pick;
                    cyc_nx   = 1'b1;
                    abort_nx = 1'b0;
                    state_nx = BUSY;
`ifdef WB_ARB_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            BUSY: begin
                // The slave cannot abort, so an owner dropping cyc only
                // marks the cycle; the bus stays up until the ack.
                if (!owner_cyc) begin
                    abort_nx = 1'b1;
                end
                if (s_ack_i) begin
                    if (!abort_q && owner_cyc) begin
                        m0_ack_o = ~owner_q;
                        m1_ack_o = owner_q;
                    end
                    cyc_nx   = 1'b0;
                    last_nx  = owner_q;
                    state_nx = IDLE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
                    if (!abort_q && owner_cyc) begin
                        m0_err_o = ~owner_q;
                        m1_err_o = owner_q;
                    end
                    cyc_nx   = 1'b0;
                    last_nx  = owner_q;
                    cnt_nx   = '0;
                    state_nx = QUIET;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            QUIET: begin
                // Let the slave finish any stray sequence; late acks are ignored here
                if (cnt_q == CNT_W'(QUIET_CYC - 1)) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                cyc_nx   = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule
